// File: rtl/data_path_pipe.sv
// data_path_pipe: CHANNELS x WIDTH register pipeline with a per-lane round function between stages,
// valid/ready handshake with bubble-collapsing backpressure, synchronous flush and occupancy count.
module data_path_pipe #(
   parameter int WIDTH      = 8,
   parameter int CHANNELS   = 2,
   parameter int DATA_DEPTH = 4,
   parameter int COMB_DEPTH = 1
) (
   input  logic                             i_clk,
   input  logic                             i_rst_n,
   input  logic                             i_flush,
   input  logic                             i_in_valid,
   output logic                             o_in_ready,
   input  logic [CHANNELS*WIDTH-1:0]        i_in_data,
   output logic                             o_out_valid,
   input  logic                             i_out_ready,
   output logic [CHANNELS*WIDTH-1:0]        o_out_data,
   output logic [$clog2(DATA_DEPTH+1)-1:0]  o_occupancy
);
   localparam int W  = CHANNELS * WIDTH;
   localparam int OW = $clog2(DATA_DEPTH + 1);

   function automatic logic [W-1:0] rounds(input logic [W-1:0] x);
      logic [W-1:0]     y;
      logic [WIDTH-1:0] l;
      y = x;
      for (int r = 0; r < COMB_DEPTH; r++)
         for (int c = 0; c < CHANNELS; c++) begin
            l = y[c*WIDTH +: WIDTH];
            y[c*WIDTH +: WIDTH] = {l[WIDTH-2:0], l[WIDTH-1]} ^ l;
         end
      return y;
   endfunction

   logic [DATA_DEPTH-1:0] r_v;
   logic [W-1:0]          r_d [DATA_DEPTH];
   logic [OW-1:0]         r_occ;
   logic [DATA_DEPTH-1:0] w_adv;
   logic [DATA_DEPTH-1:0] w_v_nxt;
   logic [W-1:0]          w_d_nxt [DATA_DEPTH];
   logic [OW-1:0]         w_cnt;

   // adv[i] unrolled: a stage moves if the consumer takes a word or any stage at or after it is empty
   always_comb begin
      logic         acc;
      logic         prev;
      logic [W-1:0] pd;
      acc   = i_out_ready;
      w_adv = '0;
      for (int i = DATA_DEPTH - 1; i >= 0; i--) begin
         acc      = acc | ~r_v[i];
         w_adv[i] = acc;
      end
      prev    = i_in_valid;
      pd      = i_in_data;
      w_v_nxt = '0;
      w_cnt   = '0;
      for (int i = 0; i < DATA_DEPTH; i++) begin
         w_v_nxt[i] = i_flush ? 1'b0 : (w_adv[i] ? prev : r_v[i]);
         w_d_nxt[i] = rounds(pd);
         w_cnt      = w_cnt + OW'(w_v_nxt[i]);
         prev       = r_v[i];
         pd         = r_d[i];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_v   <= '0;
         r_occ <= '0;
         for (int i = 0; i < DATA_DEPTH; i++) r_d[i] <= '0;
      end else begin
         r_v   <= w_v_nxt;
         r_occ <= w_cnt;
         for (int i = 0; i < DATA_DEPTH; i++) if (w_adv[i]) r_d[i] <= w_d_nxt[i];
      end
   end

   assign o_in_ready  = w_adv[0] & ~i_flush & i_rst_n;
   assign o_out_valid = r_v[DATA_DEPTH-1];
   assign o_out_data  = r_d[DATA_DEPTH-1];
   assign o_occupancy = r_occ;
endmodule

// File: tb/tb_data_path_pipe.sv
// tb_data_path_pipe: directed scoreboard bench for data_path_pipe (COMB_DEPTH 1 and a COMB_DEPTH 0 twin).
module tb_data_path_pipe;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic [15:0] in_data;
   logic        out_ready;
   logic        in_ready, out_valid, in_ready0, out_valid0;
   logic [15:0] out_data, out_data0;
   logic [2:0]  occ, occ0;
   logic [15:0] q [$];
   logic [15:0] q0 [$];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   data_path_pipe #(.WIDTH(8), .CHANNELS(2), .DATA_DEPTH(4), .COMB_DEPTH(1)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_in_valid(in_valid), .o_in_ready(in_ready),
      .i_in_data(in_data), .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
      .o_occupancy(occ));

   data_path_pipe #(.WIDTH(8), .CHANNELS(2), .DATA_DEPTH(4), .COMB_DEPTH(0)) u_dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_in_valid(in_valid), .o_in_ready(in_ready0),
      .i_in_data(in_data), .o_out_valid(out_valid0), .i_out_ready(out_ready), .o_out_data(out_data0),
      .o_occupancy(occ0));

   function automatic logic [7:0] f(input logic [7:0] x);
      return {x[6:0], x[7]} ^ x;
   endfunction

   function automatic logic [15:0] f4(input logic [15:0] x);
      logic [7:0] a, b;
      a = x[15:8];
      b = x[7:0];
      for (int k = 0; k < 4; k++) begin
         a = f(a);
         b = f(b);
      end
      return {a, b};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int k = 0; k < 40 && (q.size() != 0 || occ != 0); k++) step();
      chk("drain_q", q.size(), 0);
      chk("drain_q0", q0.size(), 0);
      chk("drain_occ", occ, 0);
   endtask

   // scoreboard: pop on output handshake, push on input acceptance
   always @(negedge clk) begin
      if (rst_n) begin
         chk("twin_in_ready", in_ready0, in_ready);
         if (out_valid && out_ready) begin
            chk("out_expected", q.size() > 0, 1);
            if (q.size() > 0) chk("out_data", out_data, q.pop_front());
         end
         if (out_valid0 && out_ready) begin
            chk("out0_expected", q0.size() > 0, 1);
            if (q0.size() > 0) chk("out0_data", out_data0, q0.pop_front());
         end
         if (flush) begin
            q.delete();
            q0.delete();
         end else if (in_valid && in_ready) begin
            q.push_back(f4(in_data));
            q0.push_back(in_data);
         end
      end
   end

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      step();
      step();
      @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_occ", occ, 0);
      step();
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_in_ready", in_ready, 1);
      step();
      // latency: single word 0x0101 -> 0x1111 after four rounds
      in_valid = 1'b1; in_data = 16'h0101;
      @(negedge clk);
      chk("lat_in_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("lat_occ", occ, (k < 4) ? 1 : 0);
         chk("lat_out_valid", out_valid, k == 3);
         if (k == 3) chk("lat_out_data", out_data, 16'h1111);
         step();
      end
      // streaming: 16 back-to-back words, no bubbles at the output
      for (int i = 0; i <= 20; i++) begin
         in_valid = i < 16;
         in_data = {8'(i), 8'(8'hF0 ^ i)};
         @(negedge clk);
         chk("stream_out_valid", out_valid, i >= 4 && i < 20);
         step();
      end
      in_valid = 1'b0;
      drain();
      // backpressure: fill, stall, release
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1; in_data = 16'h4000 + 16'(i * 16'h0123);
         @(negedge clk);
         chk("bp_in_ready", in_ready, i < 4);
         if (i == 5) chk("bp_occ_full", occ, 4);
         step();
      end
      out_ready = 1'b1; in_data = 16'h5A5A;
      @(negedge clk);
      chk("bp_release_in_ready", in_ready, 1);
      chk("bp_release_occ", occ, 4);
      step();
      in_valid = 1'b0;
      drain();
      // bubble collapse
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 16'h6001;
      step();
      in_valid = 1'b0;
      step();
      in_valid = 1'b1; in_data = 16'h6002;
      step();
      in_valid = 1'b0;
      repeat (5) step();
      @(negedge clk);
      chk("bub_occ", occ, 2);
      chk("bub_out_valid", out_valid, 1);
      step();
      in_valid = 1'b1; in_data = 16'h6003;
      @(negedge clk);
      chk("bub_in_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("bub_occ3", occ, 3);
      step();
      out_ready = 1'b1;
      drain();
      // flush
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = 16'h7000 + 16'(i);
         step();
      end
      flush = 1'b1; in_data = 16'h7777;
      @(negedge clk);
      chk("fl_in_ready", in_ready, 0);
      chk("fl_occ_before", occ, 3);
      step();
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("fl_occ", occ, 0);
      chk("fl_out_valid", out_valid, 0);
      step();
      out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h7A7A;
      @(negedge clk);
      chk("fl_next_in_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("fl_lat_out_valid", out_valid, k == 3);
         step();
      end
      drain();
      // asynchronous reset mid-stream
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1; in_data = 16'h8100 + 16'(i * 16'h1111);
         step();
      end
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_out_valid", out_valid, 0);
      chk("ar_out_data", out_data, 0);
      chk("ar_occ", occ, 0);
      chk("ar_out_valid0", out_valid0, 0);
      chk("ar_occ0", occ0, 0);
      chk("ar_in_ready", in_ready, 0);
      q.delete();
      q0.delete();
      in_valid = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("ar_no_stale", out_valid, 0);
         step();
      end
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_data = 16'($urandom);
         step();
      end
      in_valid = 1'b0;
      drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
